// File: rtl/ex_fwd_ctrl.sv
// rtl/ex_fwd_ctrl.sv - EX-stage forwarding/load-use hazard controller with shadow pipeline
// Optional feature: EX_FWD_MERGE_EN enables merged LHB/LLB forwarding (code 11) instead of a stall.
module ex_fwd_ctrl #(
    parameter int REG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             id_lhb,
    input  logic             id_llb,
    input  logic             ex_flush,
    output logic [1:0]       forwardA,
    output logic [1:0]       forwardB,
    output logic             stall
);

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             regwrite;
        logic             memread;
        logic             lhb;
        logic             llb;
    } entry_t;

    localparam entry_t BUBBLE = '0;

    entry_t     idex_q, idex_d;
    entry_t     exmem_q, exmem_d;
    entry_t     memwb_q, memwb_d;
    logic [1:0] fwd_a_q, fwd_a_d;
    logic [1:0] fwd_b_q, fwd_b_d;
    logic [2:0] dec_a, dec_b;

    function automatic logic is_producer(input entry_t e);
        return e.valid && e.regwrite && (e.rd != '0);
    endfunction

    // Returns {stall_request, forward_code} for one source operand.
    function automatic logic [2:0] decide(input logic [REG_W-1:0] src, input logic use_src,
                                          input entry_t idex, input entry_t exmem);
        logic m_idex;
        logic m_exmem;
        logic [2:0] res;
        m_idex  = use_src && is_producer(idex) && (idex.rd == src);
        m_exmem = use_src && is_producer(exmem) && (exmem.rd == src);
        res = 3'b000;
        if (m_idex && idex.lhb && m_exmem && exmem.llb) begin
`ifdef EX_FWD_MERGE_EN
            res = 3'b011;
`else
            res = 3'b100;
`endif
        end else if (m_idex && idex.memread) begin
            res = 3'b100;
        end else if (m_idex) begin
            res = 3'b010;
        end else if (m_exmem) begin
            res = 3'b001;
        end
        return res;
    endfunction

    always_comb begin
        dec_a = decide(id_rs, id_use_rs, idex_q, exmem_q);
        dec_b = decide(id_rt, id_use_rt, idex_q, exmem_q);
        stall = !ex_flush && (dec_a[2] || dec_b[2]);

        idex_d  = BUBBLE;
        exmem_d = idex_q;
        memwb_d = exmem_q;
        fwd_a_d = 2'b00;
        fwd_b_d = 2'b00;
        // A stalled or squashed ID instruction does not enter EX; its codes are redone next cycle.
        if (!ex_flush && !stall) begin
            idex_d.valid    = 1'b1;
            idex_d.rd       = id_rd;
            idex_d.regwrite = id_regwrite;
            idex_d.memread  = id_memread;
            idex_d.lhb      = id_lhb;
            idex_d.llb      = id_llb;
            fwd_a_d         = dec_a[1:0];
            fwd_b_d         = dec_b[1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q  <= BUBBLE;
            exmem_q <= BUBBLE;
            memwb_q <= BUBBLE;
            fwd_a_q <= 2'b00;
            fwd_b_q <= 2'b00;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    // MEMWB producers are served by the regfile's write-before-read, so the entry is tracked only.
    logic unused_memwb;
    assign unused_memwb = ^memwb_q;

    assign forwardA = fwd_a_q;
    assign forwardB = fwd_b_q;

endmodule

// File: doc/ex_fwd_ctrl.md
# ex_fwd_ctrl

Forwarding and hazard controller for the execute stage. It tracks the destination register of every in-flight instruction in ID/EX, EX/MEM and MEM/WB in its own shadow pipeline. It produces registered `forwardA`/`forwardB` select codes for the EX operand muxes and a one-cycle load-use stall. It sits beside the ID/EX pipeline register, reads decode-stage register fields and drives the EX operand-select inputs.

## Interface
- `REG_W`, 4: register index width (16 registers, R0 hardwired zero).
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `id_rs`, `id_rt`  in  REG_W  source register indices of the instruction in ID.
- `id_use_rs`, `id_use_rt`  in  1  instruction in ID actually reads that source.
- `id_rd`  in  REG_W  destination index of the instruction in ID.
- `id_regwrite`  in  1  instruction in ID writes `id_rd`.
- `id_memread`  in  1  instruction in ID is a load.
- `id_lhb`, `id_llb`  in  1  instruction in ID is a partial-byte write (LHB/LLB).
- `ex_flush`  in  1  taken branch resolved; squash the instructions in IF/ID and ID/EX.
- `forwardA`, `forwardB`  out  2  EX operand select: 00 regfile, 01 MEM/WB, 10 EX/MEM, 11 merged {EX/MEM[7:0], MEM/WB[7:0]}.
- `stall`  out  1  hold PC and IF/ID; bubble into ID/EX.

## Operation
- Shadow pipeline: three entries (IDEX, EXMEM, MEMWB). Each holds {valid, rd, regwrite, memread, lhb, llb}. Entries advance every cycle.
- An entry is a producer only when valid, regwrite=1 and rd≠0.
- Decision is made for the ID instruction and registered into `forwardA`/`forwardB`, so the codes are valid while that instruction is in EX. Each source is decided independently:
  - Source matches the IDEX producer with memread=0: code 10. That producer is in EX/MEM when the consumer reaches EX.
  - Else source matches the EXMEM producer: code 01.
  - Else: code 00. The MEMWB producer is covered by the regfile write-before-read.
  - Merge case: source matches the IDEX producer with lhb=1 and also the EXMEM producer with llb=1. Code 11 (see Configuration).
- Load-use: a used source matches the IDEX producer with memread=1. Assert `stall` combinationally that cycle.
  - IDEX loads a bubble (valid=0).
  - Forward codes for the held instruction are recomputed next cycle; the load is then in EXMEM, giving code 01.
- Unused sources (`id_use_*`=0) always yield 00 and never stall.

## Timing
- Reset (`rst_n`=0, asynchronous): all shadow entries invalid, `forwardA`=`forwardB`=00, `stall`=0. Outputs are held until the first rising edge after release.
- Forward codes have a latency of 1 cycle from the ID-stage inputs.
- `stall` is combinational, same cycle, and lasts exactly 1 cycle per load-use hazard.
- Back-to-back dependent loads each produce their own 1-cycle stall.
- `ex_flush` has priority over `stall`:
  - `stall` is forced to 0.
  - IDEX loads a bubble.
  - The registered forward codes load 00.
  - EXMEM/MEMWB advance normally; the branch itself is older and not squashed.
- Both sources matching the same producer: both codes are set identically.
- `rst_n` deasserted mid-stream: no partial state survives, and the pipeline restarts from empty.

## Configuration
- `EX_FWD_MERGE_EN` defined: the merge case emits code 11 with no stall.
- Not defined: the merge case stalls 1 cycle (IDEX bubble), then issues code 01. Code 11 is never produced.

## Test plan
- Reset asserted mid-run with a hazard pending → `forwardA`/`forwardB`=00 and `stall`=0 immediately; no forward is issued after release.
- ADD R3 then SUB R4,R3,R5 in consecutive cycles → `forwardA`=10 while SUB is in EX, `forwardB`=00, no stall.
- LW R2 then ADD R6,R2,R2 → `stall`=1 for exactly 1 cycle, then `forwardA`=`forwardB`=01 in ADD's EX cycle.
- Producer writing R0 followed by a consumer of R0 → codes 00, no stall.
- LLB R7 / LHB R7 / ADD R1,R7,R0 → with `EX_FWD_MERGE_EN`, `forwardA`=11 and no stall; without it, 1-cycle stall then `forwardA`=01.
- LW R2, consumer of R2 and `ex_flush`=1 in the same cycle → `stall`=0; next-cycle codes are 00.
